// File: rtl/cond_logic_pkg.sv
// Shared condition-code encodings, flag bit positions and FlagW bit meanings
// for the conditional-execution block and its condition checker.
package cond_logic_pkg;

   // Condition field encodings (Instr[31:28])
   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   // Bit positions inside the {N,Z,C,V} flag vector
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // FlagW bit meanings: [1] writes N,Z; [0] writes C,V
   localparam int FLAGW_NZ = 1;
   localparam int FLAGW_CV = 0;

   function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
      logic n, z, c, v;
      logic pass;
      n = flags[FLAG_N];
      z = flags[FLAG_Z];
      c = flags[FLAG_C];
      v = flags[FLAG_V];
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = ~z;
         COND_CS: pass = c;
         COND_CC: pass = ~c;
         COND_MI: pass = n;
         COND_PL: pass = ~n;
         COND_VS: pass = v;
         COND_VC: pass = ~v;
         COND_HI: pass = c & ~z;
         COND_LS: pass = ~c | z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = ~z & (n == v);
         COND_LE: pass = z | (n != v);
         COND_AL: pass = 1'b1;
         COND_NV: pass = 1'b1;
         default: pass = 1'b0;
      endcase
      return pass;
   endfunction

endpackage

// File: rtl/cond_logic_check.sv
// Combinational condition checker: evaluates the 4-bit condition field
// against the registered {N,Z,C,V} flags.
module cond_check
   import cond_logic_pkg::*;
(
   input  logic [3:0] Cond,
   input  logic [3:0] Flags,
   output logic       CondEx
);

   always_comb begin
      CondEx = cond_eval(Cond, Flags);
   end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution unit: flag register, condition gating of PC/reg/mem
// writes, and (with COND_PERF_CNT_EN) saturating executed/squashed counters.
module cond_logic
   import cond_logic_pkg::*;
#(
   parameter logic [3:0] FLAG_RST = 4'b0000
`ifdef COND_PERF_CNT_EN
   ,parameter int CNT_W = 16
`endif
)(
   input  logic       CLK,
   input  logic       RSTn,
   input  logic       InstrValid,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic [1:0] FlagW,
   input  logic       PCS,
   input  logic       RegW,
   input  logic       MemW,
   output logic       PCSrc,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       CondEx,
   output logic [3:0] Flags
`ifdef COND_PERF_CNT_EN
   ,output logic [CNT_W-1:0] ExecCnt,
   output logic [CNT_W-1:0] SquashCnt
`endif
);

   logic issue;

   cond_check u_cond_check (
      .Cond   (Cond),
      .Flags  (Flags),
      .CondEx (CondEx)
   );

   // Requests are suppressed during reset; CondEx itself is not.
   assign issue    = InstrValid & CondEx & RSTn;
   assign PCSrc    = PCS  & issue;
   assign RegWrite = RegW & issue;
   assign MemWrite = MemW & issue;

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         Flags <= FLAG_RST;
      end else if (InstrValid && CondEx) begin
         if (FlagW[FLAGW_NZ]) begin
            Flags[FLAG_N] <= ALUFlags[FLAG_N];
            Flags[FLAG_Z] <= ALUFlags[FLAG_Z];
         end
         if (FlagW[FLAGW_CV]) begin
            Flags[FLAG_C] <= ALUFlags[FLAG_C];
            Flags[FLAG_V] <= ALUFlags[FLAG_V];
         end
      end
   end

`ifdef COND_PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Both counters stick at all-ones rather than wrapping.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         ExecCnt   <= '0;
         SquashCnt <= '0;
      end else if (InstrValid) begin
         if (CondEx && (ExecCnt != CNT_MAX)) begin
            ExecCnt <= ExecCnt + 1'b1;
         end
         if (!CondEx && (SquashCnt != CNT_MAX)) begin
            SquashCnt <= SquashCnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cond_logic.sv
// Directed table-driven bench for cond_logic plus short hand sequences for
// reset behaviour and (with COND_PERF_CNT_EN) counter saturation.
module tb_cond_logic;

   logic       CLK;
   logic       RSTn;
   logic       InstrValid;
   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic [1:0] FlagW;
   logic       PCS, RegW, MemW;
   logic       PCSrc, RegWrite, MemWrite, CondEx;
   logic [3:0] Flags;
`ifdef COND_PERF_CNT_EN
   logic [3:0] ExecCnt, SquashCnt;
`endif

   int total = 0;
   int bad   = 0;

`ifdef COND_PERF_CNT_EN
   cond_logic #(.FLAG_RST(4'b0000), .CNT_W(4)) dut (
`else
   cond_logic #(.FLAG_RST(4'b0000)) dut (
`endif
      .CLK        (CLK),
      .RSTn       (RSTn),
      .InstrValid (InstrValid),
      .Cond       (Cond),
      .ALUFlags   (ALUFlags),
      .FlagW      (FlagW),
      .PCS        (PCS),
      .RegW       (RegW),
      .MemW       (MemW),
      .PCSrc      (PCSrc),
      .RegWrite   (RegWrite),
      .MemWrite   (MemWrite),
      .CondEx     (CondEx),
      .Flags      (Flags)
`ifdef COND_PERF_CNT_EN
      ,.ExecCnt   (ExecCnt),
      .SquashCnt  (SquashCnt)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic       rstn;
      logic       valid;
      logic [3:0] cond;
      logic [1:0] fw;
      logic [3:0] alu;
      logic       pcs, regw, memw;
      logic       ex, pcsrc, regwrite, memwrite;
      logic [3:0] flags;   // Flags expected before this vector's edge
   } vec_t;

   vec_t vt[25];

   function automatic vec_t mk(input logic rstn, input logic valid, input logic [3:0] cond,
                               input logic [1:0] fw, input logic [3:0] alu,
                               input logic pcs, input logic regw, input logic memw,
                               input logic ex, input logic pc, input logic rw, input logic mw,
                               input logic [3:0] flags);
      vec_t v;
      v.rstn = rstn; v.valid = valid; v.cond = cond; v.fw = fw; v.alu = alu;
      v.pcs = pcs; v.regw = regw; v.memw = memw;
      v.ex = ex; v.pcsrc = pc; v.regwrite = rw; v.memwrite = mw; v.flags = flags;
      return v;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rstn, input logic valid, input logic [3:0] cond,
                        input logic [1:0] fw, input logic [3:0] alu,
                        input logic pcs, input logic regw, input logic memw);
      RSTn = rstn; InstrValid = valid; Cond = cond; FlagW = fw; ALUFlags = alu;
      PCS = pcs; RegW = regw; MemW = memw;
   endtask

   // Advance to just after the next rising edge, where inputs are changed.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      vt[0]  = mk(1,1,4'b1110,2'b00,4'b0000, 1,1,1, 1,1,1,1, 4'b0000);
      vt[1]  = mk(1,1,4'b1110,2'b11,4'b0100, 0,1,0, 1,0,1,0, 4'b0000);
      vt[2]  = mk(1,1,4'b0000,2'b00,4'b1011, 0,1,0, 1,0,1,0, 4'b0100);
      vt[3]  = mk(1,1,4'b0001,2'b00,4'b0000, 0,1,0, 0,0,0,0, 4'b0100);
      vt[4]  = mk(1,1,4'b1110,2'b10,4'b1011, 0,1,0, 1,0,1,0, 4'b0100);
      vt[5]  = mk(1,1,4'b0000,2'b11,4'b0110, 0,0,1, 0,0,0,0, 4'b1000);
      vt[6]  = mk(1,0,4'b1110,2'b11,4'b0110, 1,1,1, 1,0,0,0, 4'b1000);
      vt[7]  = mk(1,1,4'b1110,2'b01,4'b0001, 0,0,0, 1,0,0,0, 4'b1000);
      vt[8]  = mk(1,1,4'b1010,2'b00,4'b0000, 1,0,0, 1,1,0,0, 4'b1001);
      vt[9]  = mk(1,1,4'b1011,2'b00,4'b0000, 1,0,0, 0,0,0,0, 4'b1001);
      vt[10] = mk(1,1,4'b1100,2'b11,4'b1101, 1,0,0, 1,1,0,0, 4'b1001);
      vt[11] = mk(1,1,4'b1100,2'b11,4'b0000, 0,1,0, 0,0,0,0, 4'b1101);
      vt[12] = mk(1,1,4'b1101,2'b00,4'b0000, 0,1,0, 1,0,1,0, 4'b1101);
      vt[13] = mk(1,1,4'b1000,2'b00,4'b0000, 0,0,1, 0,0,0,0, 4'b1101);
      vt[14] = mk(1,1,4'b1001,2'b00,4'b0000, 0,0,1, 1,0,0,1, 4'b1101);
      vt[15] = mk(1,1,4'b1111,2'b11,4'b0010, 0,0,0, 1,0,0,0, 4'b1101);
      vt[16] = mk(1,1,4'b0010,2'b00,4'b0000, 0,0,0, 1,0,0,0, 4'b0010);
      vt[17] = mk(1,1,4'b0011,2'b00,4'b0000, 0,0,0, 0,0,0,0, 4'b0010);
      vt[18] = mk(1,1,4'b0100,2'b00,4'b0000, 0,0,0, 0,0,0,0, 4'b0010);
      vt[19] = mk(1,1,4'b0101,2'b00,4'b0000, 0,0,0, 1,0,0,0, 4'b0010);
      vt[20] = mk(1,1,4'b0110,2'b00,4'b0000, 0,0,0, 0,0,0,0, 4'b0010);
      vt[21] = mk(1,1,4'b0111,2'b00,4'b0000, 0,0,0, 1,0,0,0, 4'b0010);
      vt[22] = mk(1,1,4'b1000,2'b00,4'b0000, 0,0,0, 1,0,0,0, 4'b0010);
      vt[23] = mk(0,1,4'b1110,2'b11,4'b1111, 1,1,1, 1,0,0,0, 4'b0010);
      vt[24] = mk(1,1,4'b1110,2'b00,4'b0000, 1,1,1, 1,1,1,1, 4'b0000);

      // Reset for two cycles; during reset CondEx still follows Cond vs Flags.
      drive(0,1,4'b1110,2'b11,4'b1111, 1,1,1);
      step();
      step();
      Cond = 4'b0000;
      @(negedge CLK);
      chk("rst_flags", {4'h0, Flags}, 8'h00);
      chk("rst_condex_eq", {7'h0, CondEx}, 8'h00);
      chk("rst_outs", {5'h0, PCSrc, RegWrite, MemWrite}, 8'h00);
      Cond = 4'b0001;
      #1;
      chk("rst_condex_ne", {7'h0, CondEx}, 8'h01);
      step();

      for (int i = 0; i < 25; i++) begin
         drive(vt[i].rstn, vt[i].valid, vt[i].cond, vt[i].fw, vt[i].alu,
               vt[i].pcs, vt[i].regw, vt[i].memw);
         @(negedge CLK);
         chk($sformatf("v%0d_flags", i), {4'h0, Flags}, {4'h0, vt[i].flags});
         chk($sformatf("v%0d_condex", i), {7'h0, CondEx}, {7'h0, vt[i].ex});
         chk($sformatf("v%0d_pcsrc", i), {7'h0, PCSrc}, {7'h0, vt[i].pcsrc});
         chk($sformatf("v%0d_regwrite", i), {7'h0, RegWrite}, {7'h0, vt[i].regwrite});
         chk($sformatf("v%0d_memwrite", i), {7'h0, MemWrite}, {7'h0, vt[i].memwrite});
         step();
      end
      drive(1,0,4'b1110,2'b00,4'b0000, 0,0,0);
      @(negedge CLK);
      chk("final_flags", {4'h0, Flags}, 8'h00);

      // No same-cycle bypass: a write is invisible until after the edge.
      step();
      drive(1,1,4'b1110,2'b11,4'b0100, 0,0,0);
      @(negedge CLK);
      chk("nobypass_flags", {4'h0, Flags}, 8'h00);
      Cond = 4'b0000;
      #1;
      chk("nobypass_condex", {7'h0, CondEx}, 8'h00);
      Cond = 4'b1110;
      step();
      drive(1,1,4'b0000,2'b00,4'b0000, 0,0,0);
      #1;
      chk("bypass_next_flags", {4'h0, Flags}, 8'h04);
      chk("bypass_next_condex", {7'h0, CondEx}, 8'h01);

`ifdef COND_PERF_CNT_EN
      step();
      drive(0,1,4'b1110,2'b00,4'b0000, 0,0,0);
      step();
      drive(1,1,4'b0000,2'b00,4'b0000, 0,0,0);
      @(negedge CLK);
      chk("cnt_rst_exec", {4'h0, ExecCnt}, 8'h00);
      chk("cnt_rst_squash", {4'h0, SquashCnt}, 8'h00);
      step();
      step();
      step();
      InstrValid = 1'b0;
      step();
      @(negedge CLK);
      chk("cnt_squash3", {4'h0, SquashCnt}, 8'h03);
      chk("cnt_exec0", {4'h0, ExecCnt}, 8'h00);
      drive(1,1,4'b1110,2'b00,4'b0000, 0,0,0);
      for (int k = 0; k < 20; k++) step();
      InstrValid = 1'b0;
      @(negedge CLK);
      chk("cnt_exec_sat", {4'h0, ExecCnt}, 8'h0F);
      chk("cnt_squash_hold", {4'h0, SquashCnt}, 8'h03);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cond_logic.md
COND_LOGIC -- requirements
Module: cond_logic

Interface
- REQ-001 Parameter: FLAG_RST, 4'b0000, value loaded into the flag register {N,Z,C,V} on reset.
- REQ-002 Parameter: CNT_W, 16, width of the performance counters (used only under COND_PERF_CNT_EN).
- REQ-003 Port: CLK  in  1  single clock; all state updates on the rising edge.
- REQ-004 Port: RSTn  in  1  reset, synchronous, active-low.
- REQ-005 Port: InstrValid  in  1  current instruction is real (0 = bubble/stall).
- REQ-006 Port: Cond  in  4  instruction condition field Instr[31:28].
- REQ-007 Port: ALUFlags  in  4  {N,Z,C,V} produced by the ALU this cycle.
- REQ-008 Port: FlagW  in  2  from the ALU decoder; [1] = write N,Z; [0] = write C,V.
- REQ-009 Port: PCS, RegW, MemW  in  1 each  unconditional write/branch requests from the main decoder.
- REQ-010 Port: PCSrc, RegWrite, MemWrite  out  1 each  condition-gated requests.
- REQ-011 Port: CondEx  out  1  condition passes against the current flags.
- REQ-012 Port: Flags  out  4  current registered {N,Z,C,V}.
- REQ-013 Port (COND_PERF_CNT_EN only): ExecCnt, SquashCnt  out  CNT_W each  instruction counters.

Function
- REQ-014 CondEx SHALL be combinational from Cond and registered Flags (pre-update values): 0000 Z; 0001 ~Z; 0010 C; 0011 ~C; 0100 N; 0101 ~N; 0110 V; 0111 ~V; 1000 C&~Z; 1001 ~C|Z; 1010 N==V; 1011 N!=V; 1100 ~Z&(N==V); 1101 Z|(N!=V); 1110 1; 1111 1.
- REQ-015 PCSrc/RegWrite/MemWrite SHALL equal PCS/RegW/MemW AND CondEx AND InstrValid AND RSTn, same cycle (zero latency).
- REQ-016 On a rising edge with RSTn=1, InstrValid=1, CondEx=1: Flags[3:2] <= ALUFlags[3:2] if FlagW[1]; Flags[1:0] <= ALUFlags[1:0] if FlagW[0]; unselected bits hold.
- REQ-017 Flags SHALL hold when InstrValid=0 or CondEx=0, regardless of FlagW.
- REQ-018 Updated Flags SHALL be visible on Flags and used by CondEx from the next cycle only; no same-cycle bypass.
- REQ-019 FlagW=00 SHALL leave Flags unchanged even when the instruction executes.

Reset
- REQ-020 On a rising edge with RSTn=0: Flags <= FLAG_RST; counters <= 0; flag/counter updates from that cycle are discarded.
- REQ-021 While RSTn=0, PCSrc, RegWrite, MemWrite SHALL be 0; CondEx still reflects Cond vs Flags.
- REQ-022 Reset asserted mid-program SHALL take priority over any simultaneous flag write.

Configuration
- REQ-023 Macro COND_PERF_CNT_EN defined: ExecCnt increments when InstrValid&CondEx, SquashCnt when InstrValid&~CondEx, both saturating at all-ones (no wrap), reset to 0.
- REQ-024 Macro undefined: counters, their ports and logic SHALL be absent; all other behaviour identical.

Structure
- REQ-025 Shared package SHALL hold the 4-bit condition-code constants (EQ..AL, 1111), flag bit indices N=3,Z=2,C=1,V=0, and FlagW bit meanings.
- REQ-026 Condition evaluation SHALL be a combinational sub-module cond_check (Cond, Flags -> CondEx); cond_logic holds the flag register, gating and counters.

Verification
- REQ-027 Reset, then Cond=1110, PCS=RegW=MemW=1, InstrValid=1 -> all three outputs 1; Flags=0000.
- REQ-028 Cond=1110, FlagW=11, ALUFlags=0100 -> next cycle Flags=0100; then Cond=0000 -> CondEx=1; Cond=0001 -> CondEx=0, RegWrite=0.
- REQ-029 Flags=0100, FlagW=10, ALUFlags=1011, Cond=1110 -> Flags=1000 (C,V held at 00).
- REQ-030 Flags=1000, Cond=0000 (fails), FlagW=11, ALUFlags=0110 -> Flags stay 1000, MemWrite=0; InstrValid=0 with Cond=1110 -> Flags unchanged, outputs 0.
- REQ-031 Flags=1001 (N=V): Cond=1010 -> 1, 1011 -> 0, 1100 -> 1; Flags=1101: 1100 -> 0, 1101 -> 1.
- REQ-032 RSTn=0 on same edge as FlagW=11 write -> Flags=FLAG_RST; with COND_PERF_CNT_EN and CNT_W=4, 20 executed instructions -> ExecCnt=4'hF, held.
